tick_gen: RTL
=============

# tick_gen

Programmable tick generator that sits directly upstream of the team's loadable up-counter. It produces a one-cycle `clear` pulse to load the counter with zero at the start of a run, then a one-cycle `tick` pulse every `cfg_period + 1` cycles to drive the counter's increment enable. A valid/ready config port sets the period and the mode (periodic or one-shot), and start/stop controls gate the run.

## Interface
- `WIDTH`, default 8: width of the period register and the internal prescaler count.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_period`  in  WIDTH  tick interval minus one; 0 means a tick every cycle.
- `cfg_oneshot`  in  1  1 = stop after the first tick; 0 = periodic.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accepted on a cycle where `cfg_valid & cfg_ready`.
- `start`  in  1  level sampled each cycle; begins or restarts a run.
- `stop`  in  1  level sampled each cycle; aborts a run.
- `tick`  out  1  one-cycle pulse; drives the downstream counter's `en`.
- `clear`  out  1  one-cycle pulse; drives the downstream counter's `load_x`, with `x` tied to 0.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a one-shot run completes.

## Operation
- Registers:
  - `period_q` and `oneshot_q` hold the config.
  - `cnt_q[WIDTH-1:0]` is the prescaler count.
  - `state_q` is IDLE or RUN.
- Outputs:
  - `tick`, `clear` and `done` are registered.
  - `busy = (state_q == RUN)`.
  - `cfg_ready = (state_q == IDLE)`, combinational from state.
- Config:
  - Accepted only in IDLE. `period_q` and `oneshot_q` update on the accepting edge.
  - `cfg_valid` in RUN is held off (`cfg_ready = 0`); nothing changes.
- IDLE:
  - `start & !stop` → RUN, `cnt_q <= 0`, `clear` high the next cycle.
  - Config accepted on the same edge as `start` applies to that run.
  - `start & stop` together → stay in IDLE with no outputs (stop has precedence).
- RUN, evaluated each cycle in priority order:
  1. `stop`: go to IDLE. No `tick`, no `done`.
  2. `start`: restart. `cnt_q <= 0`, `clear` pulses again, no `tick` this cycle.
  3. `cnt_q == period_q`: `tick` next cycle and `cnt_q <= 0`. If `oneshot_q`, go to IDLE and pulse `done` together with `tick`.
  4. Otherwise: `cnt_q <= cnt_q + 1`.
- Width rules:
  - `cnt_q` never exceeds `period_q`, so no wrap is possible.
  - `period_q = 2^WIDTH-1` gives a tick every `2^WIDTH` cycles.
  - All compares are unsigned at WIDTH bits.

## Timing
- Reset values, asserted asynchronously at any time, including mid-run:
  - `state_q = IDLE`; `period_q`, `oneshot_q` and `cnt_q` = 0.
  - `tick`, `clear`, `done`, `busy` = 0; `cfg_ready` = 1.
  - All outputs take these values immediately; in-flight pulses are dropped.
- With `start` sampled at edge 0 (high in cycle 0):
  - `busy` and `clear` are high in cycle 1; `cnt_q = 0` in cycle 1.
  - First `tick` is in cycle `P+2`; later ticks follow every `P+1` cycles (P = `period_q`).
- Downstream counter alignment: `clear` in cycle 1 loads 0; the first `tick` increments it to 1.
- One-shot completion:
  - `tick` and `done` are high in cycle `P+2`.
  - `busy` goes low and `cfg_ready` goes high in that same cycle.
- `stop` sampled in cycle k: `busy` is low in cycle k+1, and `tick` is low in cycle k+1 even if `cnt_q == P` in cycle k.
- `clear` and `tick` are never high in the same cycle.

## Test plan
- Reset mid-run (P=3, cycle 3): all outputs go to 0 and `cfg_ready` to 1 immediately. After release, `start` with no new config runs with P=0 (ticks every cycle from cycle 2).
- Config 3, periodic, `start` at cycle 0: `clear` in cycle 1, `tick` in cycles 5, 9, 13. `busy` stays high, `done` never asserts. Downstream counter reads 1, 2, 3 after each tick.
- Config 0, periodic: `tick` is high every cycle from cycle 2 onward. Config 255 (WIDTH=8): ticks at cycles 257 and 513, with no prescaler wrap.
- Config 2, one-shot: `tick` and `done` in cycle 4; `busy` low and `cfg_ready` high in cycle 4. A later `cfg_valid` with period 5 is accepted.
- Stop and start conflicts:
  - P=3, `stop` in cycle 4: no tick in cycle 5; `busy` low in cycle 5.
  - `start` and `stop` together in IDLE: no state change.
  - `cfg_valid` during RUN: `cfg_ready = 0` and `period_q` is unchanged.
- Restart with P=3: `start` again in cycle 3 gives `clear` in cycle 4, no tick in cycle 4, and the next tick in cycle 8.

Source files
------------

// File: rtl/tick_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_gen
//
// This is a programmable tick generator. It feeds a loadable up-counter.
// A run begins with a one-cycle `clear` pulse, which loads the counter with
// zero. After that, a one-cycle `tick` pulse fires every `cfg_period + 1`
// cycles. In one-shot mode the run ends after the first tick, and `done`
// pulses in the same cycle as that tick.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   cfg_period   tick interval minus one (0 = tick every cycle)
//   cfg_oneshot  1 = stop after first tick, 0 = periodic
//   cfg_valid    config request
//   cfg_ready    config accepted when cfg_valid & cfg_ready (high in IDLE)
//   start        begin or restart a run (level, sampled each cycle)
//   stop         abort a run (level, sampled each cycle; beats start)
//   tick         registered one-cycle pulse, drives counter enable
//   clear        registered one-cycle pulse, drives counter load-zero
//   busy         high while running
//   done         registered one-cycle pulse at one-shot completion
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             clear,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] period_q,  period_d;
  logic             oneshot_q, oneshot_d;
  logic [WIDTH-1:0] cnt_q,     cnt_d;
  logic             tick_d, clear_d, done_d;

  assign busy      = (state_q == RUN);
  assign cfg_ready = (state_q == IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    clear_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A config accepted on the same edge as start applies to that run.
        // RUN compares against period_q, which already holds the new value.
        if (cfg_valid) begin
          period_d  = cfg_period;
          oneshot_d = cfg_oneshot;
        end
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = '0;
          clear_d = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          // An abort drops a tick that is due in this cycle.
          state_d = IDLE;
        end else if (start) begin
          cnt_d   = '0;
          clear_d = 1'b1;
        end else if (cnt_q == period_q) begin
          // cnt_q returns to zero here, so it never passes period_q.
          // This holds even when period_q is all ones.
          tick_d = 1'b1;
          cnt_d  = '0;
          if (oneshot_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then samples the values from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      cnt_q     <= '0;
      tick      <= 1'b0;
      clear     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      cnt_q     <= cnt_d;
      tick      <= tick_d;
      clear     <= clear_d;
      done      <= done_d;
    end
  end

endmodule
